bit_serial_and_ctrl: RTL and testbench

Bit-serial controller that performs a WIDTH-bit bitwise AND by time-sharing a single 1-bit and_gate across all bit positions, LSB first, one bit per clock. It sits between a word-level producer and consumer, with valid/ready handshakes on both sides. It is the team's first sequenced block built on the 1-bit gate library: it trades area for a fixed WIDTH-cycle latency.

---
 rtl/nand2tetris_pkg.sv | 12 +
 rtl/and_gate.sv | 10 +
 rtl/bit_serial_and_ctrl.sv | 94 +++++++++
 tb/tb_bit_serial_and_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand2tetris_pkg.sv
// Shared definitions for the nand2tetris gate library and the sequenced blocks built on it.
package nand2tetris_pkg;

    localparam int WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/and_gate.sv
// 1-bit AND gate from the gate library.
module and_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a & b;

endmodule

// File: rtl/bit_serial_and_ctrl.sv
// Bit-serial WIDTH-bit AND: one shared and_gate evaluates one bit per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module bit_serial_and_ctrl
    import nand2tetris_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gate_y;
    logic [WIDTH-1:0] ins;

    and_gate u_and (
        .a (a_q[0]),
        .b (b_q[0]),
        .y (gate_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        // Gate output placed at the MSB; built this way so WIDTH=1 needs no special slice.
        ins            = '0;
        ins[WIDTH-1]   = gate_y;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                y_d   = (y_q >> 1) | ins;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;

endmodule

// File: tb/tb_bit_serial_and_ctrl.sv
// Scoreboard bench for bit_serial_and_ctrl at WIDTH=16 and WIDTH=1.
module tb_bit_serial_and_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0] a, b, y;
    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [0:0]   a1, b1, y1;

    always #5 clk = ~clk;

    bit_serial_and_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    bit_serial_and_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .y         (y1),
        .busy      (busy1)
    );

    typedef struct {
        int y;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t sb1[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void flag(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Monitor for the 16-bit instance.
    logic   prev_ov = 1'b0;
    logic   prev_or = 1'b0;
    int     held = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    flag("unexpected_result");
                end else begin
                    e = sb.pop_front();
                    chk("result_y", int'(y), e.y);
                    chk("latency", cyc - e.acc, W);
                end
                held = int'(y);
            end else if (out_valid && prev_ov) begin
                chk("y_stable", int'(y), held);
                chk("busy_in_done", int'(busy), 1);
                chk("in_ready_in_done", int'(in_ready), 0);
            end
            if (prev_ov) begin
                if (prev_or) begin
                    chk("drain_ov", int'(out_valid), 0);
                    chk("drain_in_ready", int'(in_ready), 1);
                end else begin
                    chk("hold_ov", int'(out_valid), 1);
                end
            end
            prev_ov = out_valid;
            prev_or = out_ready;
        end
    end

    // Monitor for the 1-bit instance.
    logic prev_ov1 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ov1 = 1'b0;
        end else begin
            if (out_valid1 && !prev_ov1) begin
                if (sb1.size() == 0) begin
                    flag("w1_unexpected_result");
                end else begin
                    e = sb1.pop_front();
                    chk("w1_result_y", int'(y1), e.y);
                    chk("w1_latency", cyc - e.acc, 1);
                end
            end
            prev_ov1 = out_valid1;
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(posedge clk); #1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) flag("timeout_in_ready");
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W-1:0] ty);
        wait_ready();
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        sb.push_back('{y: int'(ty), acc: cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_drop", int'(in_ready), 0);
        chk("busy_in_run", int'(busy), 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || sb1.size() != 0 || out_valid || out_valid1) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) flag("timeout_drain");
    endtask

    task automatic do_op1(input logic ta, input logic tb_v, input logic ty);
        int t = 0;
        @(posedge clk); #1;
        while (!in_ready1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready1) flag("w1_timeout_in_ready");
        a1[0]     = ta;
        b1[0]     = tb_v;
        in_valid1 = 1'b1;
        sb1.push_back('{y: int'(ty), acc: cyc + 1});
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("w1_in_ready_drop", int'(in_ready1), 0);
        wait_drain();
    endtask

    initial begin
        logic [W-1:0] ta_t[3];
        logic [W-1:0] tb_t[3];
        int idx;
        int last_acc;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        out_ready1 = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_y", int'(y), 0);
        #20 rst_n = 1'b1;

        do_op(16'hF0F0, 16'hFF00, 16'hF000);
        wait_drain();
        do_op(16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_drain();
        do_op(16'hAAAA, 16'h5555, 16'h0000);
        wait_drain();
        do_op(16'h8001, 16'h8001, 16'h8001);
        wait_drain();

        // Backpressure in DONE.
        out_ready = 1'b0;
        do_op(16'h3C3C, 16'h0FF0, 16'h0C30);
        begin
            int t = 0;
            while (!out_valid && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
            if (!out_valid) flag("timeout_out_valid");
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain();

        // Busy-ignore with in_valid held high: operands churn while not in IDLE.
        ta_t[0] = 16'h1357; tb_t[0] = 16'hFFFF;
        ta_t[1] = 16'hFFFF; tb_t[1] = 16'h2468;
        ta_t[2] = 16'h0F0F; tb_t[2] = 16'h3C3C;
        idx      = 0;
        last_acc = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 120 && idx <= 3; k++) begin
            if (in_ready) begin
                if (idx < 3) begin
                    a        = ta_t[idx];
                    b        = tb_t[idx];
                    in_valid = 1'b1;
                    sb.push_back('{y: int'(ta_t[idx] & tb_t[idx]), acc: cyc + 1});
                    if (idx > 0) chk("period", cyc + 1 - last_acc, W + 2);
                    last_acc = cyc + 1;
                end else begin
                    in_valid = 1'b0;
                end
                idx++;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (idx <= 3) flag("timeout_back_to_back");
        wait_drain();

        // Reset during RUN cycle 7.
        do_op(16'hABCD, 16'hFFFF, 16'hABCD);
        repeat (6) begin
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_y", int'(y), 0);
        sb.delete();
        repeat (2) begin
            @(posedge clk);
        end
        #3 rst_n = 1'b1;
        do_op(16'h1234, 16'h00FF, 16'h0034);
        wait_drain();

        do_op1(1'b1, 1'b1, 1'b1);
        do_op1(1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
